// File: rtl/shift_add_multiplier.sv
// Sequential unsigned WIDTH x WIDTH shift-and-add multiplier.
// One accumulate-and-shift step per clock. The add goes through a
// ripple_carry_adder instance. The adder's carry-out is fed back into the
// top bit of the accumulator, so no overflow is lost.
//
// Handshake: start is sampled only in IDLE or DONE. The operands a and b are
// captured at that accepting edge. busy is high for WIDTH cycles. done then
// pulses for one cycle, and product becomes valid at the same edge that raises
// done. product holds its value until the next completion or a reset.
// start while busy is ignored.

// Plain carry-ripple adder, one full-adder cell per bit.
module ripple_carry_adder #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    assign sum[i]       = a[i] ^ b[i] ^ carry[i];
    assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign cout = carry[WIDTH];

endmodule

module shift_add_multiplier #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic [1:0]         state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // The iteration counter only needs to reach WIDTH-1.
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t             state_q;
  state_t             state_d;
  logic [WIDTH-1:0]   mcand_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_step;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH-1:0]   add_sum;
  logic               add_cout;
  logic [WIDTH-1:0]   step_s;
  logic               step_c;
  logic               accept;
  logic               last_iter;

  // Upper accumulator half plus multiplicand. The carry-in is unused.
  ripple_carry_adder #(
    .WIDTH(WIDTH)
  ) u_adder (
    .a    (acc_q[2*WIDTH-1:WIDTH]),
    .b    (mcand_q),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // One iteration: add mcand when the low bit is set, then shift the
  // (2*WIDTH+1)-bit {carry, sum, lo} right by one.
  always_comb begin
    step_c = 1'b0;
    step_s = acc_q[2*WIDTH-1:WIDTH];
    if (acc_q[0]) begin
      step_c = add_cout;
      step_s = add_sum;
    end
    acc_step = {step_c, step_s, acc_q[WIDTH-1:1]};
  end

  // A new request is only honoured outside of BUSY.
  always_comb begin
    accept    = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    last_iter = (state_q == S_BUSY) && (cnt_q == LAST);
  end

  // Next-state decode. DONE lasts exactly one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_BUSY;
      S_BUSY:  if (last_iter) state_d = S_DONE;
      S_DONE:  state_d = accept ? S_BUSY : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Operand capture and the per-cycle accumulate/shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else if (accept) begin
      mcand_q <= a;
      acc_q   <= {{WIDTH{1'b0}}, b};
      cnt_q   <= '0;
    end else if (state_q == S_BUSY) begin
      acc_q   <= acc_step;
      cnt_q   <= cnt_q + 1'b1;
    end
  end

  // Registered status flags. product is loaded on the final iteration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      busy <= (state_d == S_BUSY);
      done <= (state_d == S_DONE);
      if (last_iter) begin
        product <= acc_step;
      end
    end
  end

  assign state_dbg = state_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Bench for shift_add_multiplier at WIDTH=4 and WIDTH=8.
// The reference is plain integer multiplication, and the expected timing is
// fixed: busy is high for W cycles after acceptance, then done pulses once.
`timescale 1ns/1ps
module tb_shift_add_multiplier;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        start4, busy4, done4;
  logic [3:0]  a4, b4;
  logic [7:0]  product4;
  logic [1:0]  st4;

  logic        start8, busy8, done8;
  logic [7:0]  a8, b8;
  logic [15:0] product8;
  logic [1:0]  st8;

  int tests = 0;
  int fails = 0;

  shift_add_multiplier #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .product(product4), .state_dbg(st4)
  );

  shift_add_multiplier #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .product(product8), .state_dbg(st8)
  );

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic get_busy(input int w);
    return (w == 4) ? busy4 : busy8;
  endfunction

  function automatic logic get_done(input int w);
    return (w == 4) ? done4 : done8;
  endfunction

  function automatic logic [15:0] get_product(input int w);
    return (w == 4) ? {8'd0, product4} : product8;
  endfunction

  // ---------------- drivers ----------------
  task automatic set_inputs(input int w, input logic st, input logic [7:0] ta, input logic [7:0] tb);
    if (w == 4) begin
      start4 = st; a4 = ta[3:0]; b4 = tb[3:0];
    end else begin
      start8 = st; a8 = ta; b8 = tb;
    end
  endtask

  // Called at a negedge; the next posedge is the accepting edge.
  task automatic issue(input int w, input logic [7:0] ta, input logic [7:0] tb);
    set_inputs(w, 1'b1, ta, tb);
  endtask

  // W busy cycles, then the done cycle with the expected product. Returns
  // at the negedge inside the done cycle, so the caller can chain a new start.
  // hold=1 keeps start asserted and changes a/b to 1/1 mid-operation.
  task automatic expect_op(input int w, input logic [15:0] exp, input bit hold, input string tag);
    for (int i = 0; i < w; i++) begin
      @(negedge clk);
      check({tag, " busy"}, 16'(get_busy(w)), 16'd1);
      check({tag, " done_low"}, 16'(get_done(w)), 16'd0);
      if (!hold) begin
        set_inputs(w, 1'b0, 8'($urandom), 8'($urandom));
      end else if (i == 1) begin
        set_inputs(w, 1'b1, 8'd1, 8'd1);
      end
    end
    @(negedge clk);
    check({tag, " done"}, 16'(get_done(w)), 16'd1);
    check({tag, " busy_low"}, 16'(get_busy(w)), 16'd0);
    check({tag, " product"}, get_product(w), exp);
  endtask

  // Idle cycles: no activity, and product must hold.
  task automatic idle(input int w, input int n, input logic [15:0] exp, input string tag);
    set_inputs(w, 1'b0, 8'($urandom), 8'($urandom));
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check({tag, " idle_busy"}, 16'(get_busy(w)), 16'd0);
      check({tag, " idle_done"}, 16'(get_done(w)), 16'd0);
      check({tag, " hold"}, get_product(w), exp);
    end
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [7:0]  ra, rb;
    logic [15:0] e;

    rst_n = 1'b0;
    set_inputs(4, 1'b0, 8'd0, 8'd0);
    set_inputs(8, 1'b0, 8'd0, 8'd0);
    @(negedge clk);
    @(negedge clk);
    check("reset busy4", 16'(busy4), 16'd0);
    check("reset done4", 16'(done4), 16'd0);
    check("reset product4", {8'd0, product4}, 16'd0);
    check("reset busy8", 16'(busy8), 16'd0);
    check("reset product8", product8, 16'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic products, each followed by ten idle cycles.
    issue(4, 8'd13, 8'd11); expect_op(4, 16'd143, 1'b0, "13x11"); idle(4, 10, 16'd143, "13x11");
    issue(4, 8'd15, 8'd15); expect_op(4, 16'd225, 1'b0, "15x15"); idle(4, 10, 16'd225, "15x15");
    issue(4, 8'd0,  8'd9);  expect_op(4, 16'd0,   1'b0, "0x9");   idle(4, 10, 16'd0,   "0x9");
    issue(4, 8'd9,  8'd0);  expect_op(4, 16'd0,   1'b0, "9x0");   idle(4, 10, 16'd0,   "9x0");

    // start held through BUSY, with the operands changed mid-operation.
    issue(4, 8'd6, 8'd7); expect_op(4, 16'd42, 1'b1, "hold6x7");
    idle(4, 3, 16'd42, "hold6x7");

    // Back-to-back: restart in the DONE cycle.
    issue(4, 8'd7, 8'd9); expect_op(4, 16'd63, 1'b0, "b2b7x9");
    issue(4, 8'd3, 8'd5); expect_op(4, 16'd15, 1'b0, "b2b3x5");
    idle(4, 2, 16'd15, "b2b3x5");

    // Asynchronous reset between clock edges while busy.
    issue(4, 8'd5, 8'd5);
    @(negedge clk);
    set_inputs(4, 1'b0, 8'd0, 8'd0);
    @(negedge clk);
    check("pre_reset busy", 16'(busy4), 16'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async busy", 16'(busy4), 16'd0);
    check("async done", 16'(done4), 16'd0);
    check("async product", {8'd0, product4}, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(4, 8'd2, 8'd2); expect_op(4, 16'd4, 1'b0, "post_reset2x2");
    idle(4, 1, 16'd4, "post_reset2x2");

    // Random back-to-back regression. Fixed done spacing of W+1 is checked.
    for (int n = 0; n < 1000; n++) begin
      ra = 8'($urandom_range(0, 15));
      rb = 8'($urandom_range(0, 15));
      e  = 16'(ra) * 16'(rb);
      issue(4, ra, rb);
      expect_op(4, e, 1'b0, "rand4");
    end
    idle(4, 1, e, "rand4_end");

    for (int n = 0; n < 1000; n++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      e  = 16'(ra) * 16'(rb);
      issue(8, ra, rb);
      expect_op(8, e, 1'b0, "rand8");
    end
    idle(8, 1, e, "rand8_end");

    // Operand corners at WIDTH=8.
    issue(8, 8'd255, 8'd255); expect_op(8, 16'd65025, 1'b0, "255x255");
    idle(8, 3, 16'd65025, "255x255");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/shift_add_multiplier.md
Name: shift_add_multiplier

Overview:
- Sequential unsigned WIDTH x WIDTH multiplier using the shift-and-add method; produces a 2*WIDTH product.
- Sits directly upstream of the team's ripple_carry_adder and drives it. Each cycle it supplies the accumulator's upper half and the multiplicand to one ripple_carry_adder instance (WIDTH, cin tied 0), then consumes sum and cout.
- Intended as the area-lean multiply in the arithmetic datapath. Uses a start/busy/done handshake.

Parameters:
- WIDTH, 4, operand width in bits (>=2); product width is 2*WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE or DONE
- a  input  WIDTH  multiplicand (unsigned)
- b  input  WIDTH  multiplier (unsigned)
- busy  output  1  high while a multiply is in progress
- done  output  1  one-cycle pulse when product becomes valid
- product  output  2*WIDTH  result; held until the next completion

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, named rst_n.
- Reset (rst_n=0, asynchronous):
  - state=IDLE; busy=0, done=0, product=0.
  - Internal accumulator, multiplicand register and counter cleared.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: start=1 at an edge -> capture mcand<=a, acc<={WIDTH'0, b}, cnt<=0, go to BUSY.
  - BUSY: one iteration per cycle; after iteration cnt==WIDTH-1 go to DONE.
  - DONE: lasts exactly one cycle. If start=1, capture new operands and go to BUSY (back-to-back). Otherwise go to IDLE.
- Iteration, with acc = {hi[WIDTH-1:0], lo[WIDTH-1:0]}:
  - If lo[0]=1: {c, s} = hi + mcand via the adder. Otherwise {c, s} = {0, hi}.
  - Update acc <= {c, s, lo} >> 1, i.e. a 2*WIDTH+1-bit shift keeping the low 2*WIDTH bits.
  - The carry must not be lost; the hi+mcand overflow enters bit 2*WIDTH-1.
- Outputs:
  - busy = (state==BUSY), registered decode.
  - done = (state==DONE).
  - product is loaded from acc on the BUSY->DONE transition and is valid at the same edge done rises. It holds afterwards; it is not cleared by going IDLE or by a new start.
- Latency: start sampled at edge k -> busy=1 for cycles k+1..k+WIDTH -> done=1 in cycle k+WIDTH+1. Throughput is one result per WIDTH+1 cycles.
- start while BUSY: ignored; no effect on operands or count.
- a/b may change freely after capture; only values at the accepting edge are used.
- Arithmetic: result is exact for all inputs; max (2^W-1)^2 fits in 2*WIDTH bits, with no truncation.
- Reset mid-operation: immediate abort to the reset values above; prior product is lost (reads 0).

Test Plan:
- WIDTH=4: a=13, b=11, start pulse at edge k -> busy high 4 cycles, done pulse at k+5, product=143 (0x8F).
- a=15, b=15 (carry path) -> product=225 (0xE1). a=0, b=9 -> 0. a=9, b=0 -> 0. After each, product holds across 10 idle cycles.
- start held high throughout BUSY with a/b changed to 1/1 mid-op, original a=6, b=7 -> single done pulse, product=42; no restart until DONE.
- Back-to-back: start=1 in the DONE cycle with a=3, b=5, after a prior 7*9 -> first product=63; busy reasserts next cycle, second done 5 cycles later, product=15.
- rst_n asserted asynchronously mid-BUSY (between clock edges) -> busy, done and product go 0 immediately. After release, 2*2 -> 4 with normal latency.
- Random regression of 1000 operand pairs at WIDTH=4 and WIDTH=8 against a reference product: all match, and the done-to-start spacing is always WIDTH+1 cycles.
